// File: rtl/axis_video_pkg.sv
// Shared definitions for the 64-bit sync-coded video stream: tuser bit positions,
// frame generator FSM states, pattern selection and row sizing helpers.
package axis_video_pkg;

  localparam int TU_SOF = 0;
  localparam int TU_EOF = 1;
  localparam int TU_SOL = 2;
  localparam int TU_EOL = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_LINE, ST_DONE} fg_state_e;

  typedef enum logic {PAT_RAMP = 1'b0, PAT_ROW_OFS = 1'b1} pattern_e;

  // ceil(x_size * pixel_width / 8); 8191 * 4 bytes still fits 16 bits
  function automatic logic [12:0] beats_per_row(input logic [12:0] x_size,
                                                input logic [2:0]  pw);
    logic [15:0] nbytes;
    nbytes = 16'(x_size) * 16'(pw);
    return 13'((nbytes + 16'd7) >> 3);
  endfunction

  function automatic logic [3:0] sync_code(input logic first, input logic last,
                                           input logic first_row, input logic last_row);
    logic [3:0] u;
    u = '0;
    if (first) u[first_row ? TU_SOF : TU_SOL] = 1'b1;
    if (last)  u[last_row  ? TU_EOF : TU_EOL] = 1'b1;
    return u;
  endfunction

endpackage

// File: rtl/axis_frame_gen_lane_pack.sv
// Combinational 8-lane byte generator: walks pixel/component counters across the
// lanes of one beat and returns the packed word plus the state for the next beat.
module axis_frame_gen_lane_pack #(
  parameter int XW = 13
) (
  input  logic [2:0]    pixel_width,
  input  logic [XW-1:0] x_size,
  input  logic [7:0]    ofs,
  input  logic [XW:0]   pix_start,
  input  logic [1:0]    comp_start,
  output logic [63:0]   data,
  output logic [XW:0]   pix_next,
  output logic [1:0]    comp_next
);

  logic [1:0]  comp_last;
  logic [XW:0] p;
  logic [1:0]  c;

  assign comp_last = 2'(pixel_width - 3'd1);

  // Each lane takes the previous lane's counters; no division in the byte path
  always_comb begin
    p    = pix_start;
    c    = comp_start;
    data = '0;
    for (int i = 0; i < 8; i++) begin
      if (p < {1'b0, x_size}) data[i*8 +: 8] = p[7:0] + ofs;
      if (c == comp_last) begin
        p = p + 1'b1;
        c = '0;
      end else begin
        c = c + 2'd1;
      end
    end
    pix_next  = p;
    comp_next = c;
  end

endmodule

// File: rtl/axis_frame_gen.sv
// AXI-stream test frame source: ramp / row-offset ramp rows with SOF/SOL/EOL/EOF
// tuser codes, per-row tlast and a programmable idle gap ahead of every row.
module axis_frame_gen
  import axis_video_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_X_SIZE = 8191,
  parameter int MAX_Y_SIZE = 8191,
  parameter int GAP_WIDTH  = 16,
  localparam int XW = $clog2(MAX_X_SIZE + 1),
  localparam int YW = $clog2(MAX_Y_SIZE + 1)
) (
  input  logic                  aclk,
  input  logic                  aclk_reset,
  input  logic                  aclk_start,
  input  logic [2:0]            aclk_pixel_width,
  input  logic [XW-1:0]         aclk_x_size,
  input  logic [YW-1:0]         aclk_y_size,
  input  logic [GAP_WIDTH-1:0]  aclk_line_gap,
  input  logic                  aclk_pattern_sel,
  output logic                  aclk_busy,
  output logic                  aclk_done,
  output logic                  aclk_cfg_error,
  output logic [15:0]           aclk_frame_cnt,
  input  logic                  aclk_tready,
  output logic                  aclk_tvalid,
  output logic [3:0]            aclk_tuser,
  output logic                  aclk_tlast,
  output logic [DATA_WIDTH-1:0] aclk_tdata
);

  fg_state_e            state_q, state_d;
  logic [2:0]           pw_q;
  logic [XW-1:0]        x_q;
  logic [YW-1:0]        y_q, row_q;
  logic [GAP_WIDTH-1:0] gap_q, gap_cnt;
  pattern_e             pat_q;
  logic [12:0]          beats_q, beat_q;
  logic [XW:0]          pix_q, lp_pix_next;
  logic [1:0]           comp_q, lp_comp_next;
  logic [63:0]          lp_data;
  logic [7:0]           ofs;
  logic                 cfg_ok, accept, last_beat, last_row, gap_done, next_is_last;

  assign cfg_ok       = (aclk_pixel_width != 3'd0) && (aclk_pixel_width <= 3'd4) &&
                        (aclk_x_size != '0) && (aclk_y_size != '0);
  assign accept       = aclk_tvalid & aclk_tready;
  assign last_beat    = (beat_q == beats_q - 13'd1);
  assign next_is_last = (beat_q + 13'd1 == beats_q - 13'd1);
  assign last_row     = (row_q == y_q - 1'b1);
  assign gap_done     = (gap_cnt == gap_q);
  assign ofs          = (pat_q == PAT_ROW_OFS) ? row_q[7:0] : 8'd0;

  axis_frame_gen_lane_pack #(.XW(XW)) u_pack (
    .pixel_width (pw_q),
    .x_size      (x_q),
    .ofs         (ofs),
    .pix_start   (pix_q),
    .comp_start  (comp_q),
    .data        (lp_data),
    .pix_next    (lp_pix_next),
    .comp_next   (lp_comp_next)
  );

  always_ff @(posedge aclk) begin
    if (aclk_reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    aclk_busy = (state_q != ST_IDLE);
    aclk_done = 1'b0;
    unique case (state_q)
      ST_IDLE: if (aclk_start && cfg_ok) state_d = ST_GAP;
      ST_GAP:  if (gap_done) state_d = ST_LINE;
      ST_LINE: if (accept && last_beat) state_d = last_row ? ST_DONE : ST_GAP;
      ST_DONE: begin
        aclk_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      pw_q           <= '0;
      x_q            <= '0;
      y_q            <= '0;
      gap_q          <= '0;
      pat_q          <= PAT_RAMP;
      beats_q        <= '0;
      beat_q         <= '0;
      row_q          <= '0;
      gap_cnt        <= '0;
      pix_q          <= '0;
      comp_q         <= '0;
      aclk_cfg_error <= 1'b0;
      aclk_frame_cnt <= '0;
      aclk_tvalid    <= 1'b0;
      aclk_tuser     <= '0;
      aclk_tlast     <= 1'b0;
      aclk_tdata     <= '0;
    end else begin
      aclk_cfg_error <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (aclk_start) begin
          pw_q           <= aclk_pixel_width;
          x_q            <= aclk_x_size;
          y_q            <= aclk_y_size;
          gap_q          <= aclk_line_gap;
          pat_q          <= pattern_e'(aclk_pattern_sel);
          beats_q        <= beats_per_row(13'(aclk_x_size), aclk_pixel_width);
          row_q          <= '0;
          gap_cnt        <= '0;
          pix_q          <= '0;
          comp_q         <= '0;
          aclk_cfg_error <= !cfg_ok;
        end
        ST_GAP: begin
          if (gap_done) begin
            aclk_tvalid <= 1'b1;
            aclk_tdata  <= DATA_WIDTH'(lp_data);
            aclk_tuser  <= sync_code(1'b1, beats_q == 13'd1, row_q == '0, last_row);
            aclk_tlast  <= (beats_q == 13'd1);
            beat_q      <= '0;
            pix_q       <= lp_pix_next;
            comp_q      <= lp_comp_next;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_LINE: if (accept) begin
          if (last_beat) begin
            aclk_tvalid <= 1'b0;
            aclk_tdata  <= '0;
            aclk_tuser  <= '0;
            aclk_tlast  <= 1'b0;
            pix_q       <= '0;
            comp_q      <= '0;
            gap_cnt     <= '0;
            if (!last_row) row_q <= row_q + 1'b1;
          end else begin
            aclk_tdata <= DATA_WIDTH'(lp_data);
            aclk_tuser <= sync_code(1'b0, next_is_last, row_q == '0, last_row);
            aclk_tlast <= next_is_last;
            beat_q     <= beat_q + 13'd1;
            pix_q      <= lp_pix_next;
            comp_q     <= lp_comp_next;
          end
        end
        ST_DONE: aclk_frame_cnt <= aclk_frame_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen: a division-based reference model queues the
// expected beats per frame, a negedge monitor pops and compares accepted beats.
module tb_axis_frame_gen;

  logic        aclk = 1'b0;
  logic        aclk_reset, aclk_start, aclk_pattern_sel, aclk_tready;
  logic [2:0]  aclk_pixel_width;
  logic [12:0] aclk_x_size, aclk_y_size;
  logic [15:0] aclk_line_gap;
  logic        aclk_busy, aclk_done, aclk_cfg_error, aclk_tvalid, aclk_tlast;
  logic [15:0] aclk_frame_cnt;
  logic [3:0]  aclk_tuser;
  logic [63:0] aclk_tdata;

  always #5 aclk = ~aclk;

  axis_frame_gen dut (
    .aclk(aclk), .aclk_reset(aclk_reset), .aclk_start(aclk_start),
    .aclk_pixel_width(aclk_pixel_width), .aclk_x_size(aclk_x_size),
    .aclk_y_size(aclk_y_size), .aclk_line_gap(aclk_line_gap),
    .aclk_pattern_sel(aclk_pattern_sel), .aclk_busy(aclk_busy),
    .aclk_done(aclk_done), .aclk_cfg_error(aclk_cfg_error),
    .aclk_frame_cnt(aclk_frame_cnt), .aclk_tready(aclk_tready),
    .aclk_tvalid(aclk_tvalid), .aclk_tuser(aclk_tuser),
    .aclk_tlast(aclk_tlast), .aclk_tdata(aclk_tdata)
  );

  typedef struct {
    logic [63:0] d;
    logic [3:0]  u;
    logic        l;
  } beat_t;

  beat_t sb[$];
  int    total = 0, bad = 0;
  int    acc_cnt = 0, frames = 0;
  logic  rnd_mode = 1'b0, rnd_bit = 1'b1, tready_fix = 1'b1;

  assign aclk_tready = rnd_mode ? rnd_bit : tready_fix;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [63:0] model_data(int pw, int x, int pat, int row, int beat);
    logic [63:0] d;
    int p;
    d = '0;
    for (int b = 0; b < 8; b++) begin
      p = (beat * 8 + b) / pw;
      if (p < x) d[b*8 +: 8] = 8'((p + (pat != 0 ? row : 0)) & 255);
    end
    return d;
  endfunction

  task automatic push_frame(input int pw, input int x, input int y, input int pat);
    beat_t e;
    int nb;
    nb = (x * pw + 7) / 8;
    for (int r = 0; r < y; r++)
      for (int k = 0; k < nb; k++) begin
        e.d = model_data(pw, x, pat, r, k);
        e.u = 4'(((k == 0) ? ((r == 0) ? 1 : 4) : 0) |
                 ((k == nb - 1) ? ((r == y - 1) ? 2 : 8) : 0));
        e.l = (k == nb - 1);
        sb.push_back(e);
      end
  endtask

  always @(posedge aclk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  logic        held_v = 1'b0;
  beat_t       held;
  always @(negedge aclk) begin
    beat_t e;
    if (aclk_reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_tvalid", 64'(aclk_tvalid), 64'd1);
        chk("hold_tdata", aclk_tdata, held.d);
        chk("hold_tuser", 64'(aclk_tuser), 64'(held.u));
        chk("hold_tlast", 64'(aclk_tlast), 64'(held.l));
      end
      held_v = aclk_tvalid && !aclk_tready;
      held.d = aclk_tdata;
      held.u = aclk_tuser;
      held.l = aclk_tlast;
      if (aclk_tvalid && aclk_tready) begin
        acc_cnt++;
        if (sb.size() == 0) begin
          chk("extra_beat", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("tdata", aclk_tdata, e.d);
          chk("tuser", 64'(aclk_tuser), 64'(e.u));
          chk("tlast", 64'(aclk_tlast), 64'(e.l));
        end
      end
    end
  end

  task automatic set_cfg(input int pw, input int x, input int y, input int gap, input int pat);
    aclk_pixel_width = 3'(pw);
    aclk_x_size      = 13'(x);
    aclk_y_size      = 13'(y);
    aclk_line_gap    = 16'(gap);
    aclk_pattern_sel = 1'(pat);
  endtask

  task automatic run_frame(input int pw, input int x, input int y, input int gap,
                           input int pat, input logic rnd, input logic restart);
    int n, dones, cyc;
    push_frame(pw, x, y, pat);
    rnd_mode = rnd;
    set_cfg(pw, x, y, gap, pat);
    aclk_start = 1'b1;
    step();
    aclk_start = 1'b0;
    set_cfg(1, 7, 1, 0, 1 - pat);
    n = 1;
    while (!aclk_tvalid && n < gap + 20) begin
      step();
      n++;
    end
    chk("first_latency", 64'(n), 64'(gap + 2));
    chk("busy_in_frame", 64'(aclk_busy), 64'd1);
    if (restart) begin
      aclk_start = 1'b1;
      step();
      aclk_start = 1'b0;
      chk("busy_start_no_err", 64'(aclk_cfg_error), 64'd0);
    end
    dones = 0;
    cyc = 0;
    while (dones == 0 && cyc < 40000) begin
      step();
      cyc++;
      if (aclk_done) dones++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (aclk_done) dones++;
    end
    frames++;
    rnd_mode = 1'b0;
    chk("done_once", 64'(dones), 64'd1);
    chk("busy_after", 64'(aclk_busy), 64'd0);
    chk("frame_cnt", 64'(aclk_frame_cnt), 64'(frames));
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n;
    aclk_reset = 1'b1;
    aclk_start = 1'b0;
    set_cfg(1, 1, 1, 0, 0);
    repeat (3) step();
    chk("rst_tvalid", 64'(aclk_tvalid), 64'd0);
    chk("rst_busy", 64'(aclk_busy), 64'd0);
    chk("rst_done", 64'(aclk_done), 64'd0);
    chk("rst_cfg_err", 64'(aclk_cfg_error), 64'd0);
    chk("rst_frame_cnt", 64'(aclk_frame_cnt), 64'd0);
    chk("rst_tdata", aclk_tdata, 64'd0);
    aclk_reset = 1'b0;
    step();

    // Abort mid-frame at row 2 beat 4 (8 beats per row)
    push_frame(1, 64, 4, 0);
    set_cfg(1, 64, 4, 2, 0);
    aclk_start = 1'b1;
    step();
    aclk_start = 1'b0;
    n = 0;
    while (acc_cnt < 20 && n < 200) begin
      step();
      n++;
    end
    chk("abort_reached", 64'(acc_cnt), 64'd20);
    aclk_reset = 1'b1;
    tready_fix = 1'b0;
    step();
    chk("abort_tvalid", 64'(aclk_tvalid), 64'd0);
    chk("abort_busy", 64'(aclk_busy), 64'd0);
    chk("abort_done", 64'(aclk_done), 64'd0);
    chk("abort_frame_cnt", 64'(aclk_frame_cnt), 64'd0);
    aclk_reset = 1'b0;
    sb.delete();
    tready_fix = 1'b1;
    step();

    run_frame(1, 256, 5, 0, 0, 1'b0, 1'b0);
    run_frame(3, 5, 2, 1, 0, 1'b0, 1'b0);
    run_frame(2, 13, 4, 3, 1, 1'b1, 1'b1);
    run_frame(1, 2, 3, 0, 0, 1'b0, 1'b0);

    // Rejected configurations: pulse, no busy, no beats
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: set_cfg(5, 8, 2, 0, 0);
        1: set_cfg(0, 8, 2, 0, 0);
        2: set_cfg(2, 8, 0, 0, 0);
        default: set_cfg(2, 0, 2, 0, 0);
      endcase
      aclk_start = 1'b1;
      step();
      aclk_start = 1'b0;
      chk("cfg_err_pulse", 64'(aclk_cfg_error), 64'd1);
      chk("cfg_err_busy", 64'(aclk_busy), 64'd0);
      step();
      chk("cfg_err_clear", 64'(aclk_cfg_error), 64'd0);
      chk("cfg_err_tvalid", 64'(aclk_tvalid), 64'd0);
    end

    run_frame(4, 8191, 2, 0, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
